// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse message sequencer.
//   letter_t       : 3-bit letter code, A..H
//   state_t        : transmit FSM states
//   MORSE_PATTERN  : 12-bit dot/dash pattern per letter, sent MSB first
//   MORSE_LEN      : number of significant bits per letter (position of last 1)
//   letter_len()   : bits actually transmitted for a letter
// Build option: define MORSE_TRIM_EN to stop each letter after its last 1
// instead of sending all 12 bits.
// ---------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        LTR_A, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H
    } letter_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } state_t;

    localparam int MORSE_BITS = 12;

    localparam logic [MORSE_BITS-1:0] MORSE_PATTERN [8] = '{
        12'b101110000000,   // A
        12'b111010101000,   // B
        12'b111010111010,   // C
        12'b111010100000,   // D
        12'b100000000000,   // E
        12'b101011101000,   // F
        12'b111011101000,   // G
        12'b101010100000    // H
    };

    localparam logic [3:0] MORSE_LEN [8] = '{
        4'd5, 4'd9, 4'd11, 4'd7, 4'd1, 4'd9, 4'd9, 4'd7
    };

`ifdef MORSE_TRIM_EN
    localparam bit TRIM_EN = 1'b1;
`else
    localparam bit TRIM_EN = 1'b0;
`endif

    // Number of bits put on the line for a letter before its gap.
    function automatic logic [3:0] letter_len(input letter_t l);
        return TRIM_EN ? MORSE_LEN[l] : 4'(MORSE_BITS);
    endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// ---------------------------------------------------------------------------
// morse_letter_fifo
// Small synchronous FIFO holding queued letter codes.
//   ClockIn  : clock
//   Reset    : synchronous, active-high reset (empties the queue)
//   flush_i  : empty the queue on the next edge; a push that cycle is dropped
//   push_i   : write data_i (ignored when full)
//   data_i   : letter code in
//   pop_i    : discard the head entry (ignored when empty)
//   data_o   : head entry (valid when !empty_o)
//   full_o   : no free entries
//   empty_o  : no entries
//   count_o  : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module morse_letter_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     ClockIn,
    input  logic                     Reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ClockIn) begin
        if (Reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge ClockIn) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/morse_message_sequencer.sv
// ---------------------------------------------------------------------------
// morse_message_sequencer
// Queues Morse letters (A..H) and transmits them back-to-back as a dot/dash
// bit stream, each letter followed by GAP_BITS zero bit-periods.
//   ClockIn      : clock
//   Reset        : synchronous, active-high reset
//   Flush        : abort current letter, empty the queue
//   LetterValid  : producer offers Letter
//   Letter       : letter code, 0=A .. 7=H
//   LetterReady  : queue accepts; transfer on LetterValid && LetterReady
//   DotDashOut   : current Morse bit
//   NewBitOut    : pulse on the last cycle of each bit period
//   LetterDone   : pulse on the last cycle of a letter's gap
//   Busy         : FSM not idle
//   QueueCount   : letters waiting in the queue
// Parameters: CLOCK_FREQUENCY (bit period = CLOCK_FREQUENCY/2 cycles, even,
// >= 4), FIFO_DEPTH (power of two, >= 2), GAP_BITS (>= 0).
// Build option: MORSE_TRIM_EN drops each letter's trailing zeros.
// ---------------------------------------------------------------------------
module morse_message_sequencer
    import morse_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_BITS        = 3
) (
    input  logic                          ClockIn,
    input  logic                          Reset,
    input  logic                          Flush,
    input  logic                          LetterValid,
    input  logic [2:0]                    Letter,
    output logic                          LetterReady,
    output logic                          DotDashOut,
    output logic                          NewBitOut,
    output logic                          LetterDone,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   QueueCount
);

    localparam int TICKS  = CLOCK_FREQUENCY / 2;
    localparam int TICK_W = $clog2(TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);

    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam bit NO_GAP = (GAP_BITS == 0);

    state_t                  state_q,     state_d;
    logic [TICK_W-1:0]       tick_q,      tick_d;
    logic [MORSE_BITS-1:0]   shreg_q,     shreg_d;
    logic [3:0]              bits_left_q, bits_left_d;
    logic [GAP_W-1:0]        gap_left_q,  gap_left_d;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [2:0] fifo_head;
    letter_t    head_letter;
    logic       tick_zero;

    assign LetterReady = !fifo_full && !Flush && !Reset;
    assign head_letter = letter_t'(fifo_head);
    assign tick_zero   = (tick_q == '0);

    morse_letter_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .flush_i (Flush),
        .push_i  (LetterValid && LetterReady),
        .data_i  (Letter),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (QueueCount)
    );

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q     <= IDLE;
            tick_q      <= TICK_LAST;
            shreg_q     <= '0;
            bits_left_q <= '0;
            gap_left_q  <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            gap_left_q  <= gap_left_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        gap_left_d  = gap_left_q;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tick_d = TICK_LAST;
                if (!fifo_empty) state_d = LOAD;
            end

            LOAD: begin
                fifo_pop    = 1'b1;
                shreg_d     = MORSE_PATTERN[head_letter];
                bits_left_d = letter_len(head_letter) - 4'd1;
                tick_d      = TICK_LAST;
                state_d     = SEND;
            end

            SEND: begin
                tick_d = tick_zero ? TICK_LAST : tick_q - 1'b1;
                if (tick_zero) begin
                    if (bits_left_q == '0) begin
                        // With no gap the letter finishes on its last bit.
                        if (NO_GAP) begin
                            state_d = fifo_empty ? IDLE : LOAD;
                        end else begin
                            state_d    = GAP;
                            gap_left_d = GAP_LAST;
                        end
                    end else begin
                        shreg_d     = shreg_q << 1;
                        bits_left_d = bits_left_q - 1'b1;
                    end
                end
            end

            GAP: begin
                tick_d = tick_zero ? TICK_LAST : tick_q - 1'b1;
                if (tick_zero) begin
                    // Emptiness is the registered view, so a push landing on
                    // this same edge waits for the IDLE->LOAD path.
                    if (gap_left_q == '0) state_d = fifo_empty ? IDLE : LOAD;
                    else                  gap_left_d = gap_left_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (Flush) begin
            state_d  = IDLE;
            tick_d   = TICK_LAST;
            fifo_pop = 1'b0;
        end
    end

    // Outputs decode registered state only.
    assign DotDashOut = (state_q == SEND) && shreg_q[MORSE_BITS-1];
    assign NewBitOut  = ((state_q == SEND) || (state_q == GAP)) && tick_zero;
    assign LetterDone = tick_zero &&
                        (((state_q == GAP) && (gap_left_q == '0)) ||
                         (NO_GAP && (state_q == SEND) && (bits_left_q == '0)));
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_message_sequencer.sv
// ---------------------------------------------------------------------------
// tb_morse_message_sequencer
// Directed bench for morse_message_sequencer with TICKS=4, FIFO_DEPTH=4,
// GAP_BITS=3. Expected bit streams come from a hand-written pattern table;
// the trimmed lengths are used when MORSE_TRIM_EN is defined.
// ---------------------------------------------------------------------------
module tb_morse_message_sequencer;

    localparam int CLK_FREQ = 8;
    localparam int TICKS    = 4;
    localparam int DEPTH    = 4;
    localparam int GAP      = 3;

    logic       ClockIn = 1'b0;
    logic       Reset;
    logic       Flush;
    logic       LetterValid;
    logic [2:0] Letter;
    logic       LetterReady;
    logic       DotDashOut;
    logic       NewBitOut;
    logic       LetterDone;
    logic       Busy;
    logic [2:0] QueueCount;

    int checks   = 0;
    int failures = 0;

    logic [11:0] pat     [8];
    int          len_tab [8];

    morse_message_sequencer #(
        .CLOCK_FREQUENCY (CLK_FREQ),
        .FIFO_DEPTH      (DEPTH),
        .GAP_BITS        (GAP)
    ) dut (
        .ClockIn     (ClockIn),
        .Reset       (Reset),
        .Flush       (Flush),
        .LetterValid (LetterValid),
        .Letter      (Letter),
        .LetterReady (LetterReady),
        .DotDashOut  (DotDashOut),
        .NewBitOut   (NewBitOut),
        .LetterDone  (LetterDone),
        .Busy        (Busy),
        .QueueCount  (QueueCount)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called in the LOAD cycle; returns in the cycle carrying LetterDone.
    // Checks {Busy, DotDashOut, NewBitOut, LetterDone} every cycle.
    task automatic expect_letter(input int idx, input string name);
        logic [11:0] p;
        int          n;
        logic        bit_v;
        p = pat[idx];
        n = len_tab[idx];
        check({name, " load"}, {Busy, DotDashOut, NewBitOut, LetterDone}, 4'b1000);
        for (int b = 0; b < n + GAP; b++) begin
            for (int t = 0; t < TICKS; t++) begin
                @(negedge ClockIn);
                bit_v = (b < n) ? p[11 - b] : 1'b0;
                check($sformatf("%s bit%0d cyc%0d", name, b, t),
                      {Busy, DotDashOut, NewBitOut, LetterDone},
                      {1'b1, bit_v, (t == TICKS - 1), (t == TICKS - 1) && (b == n + GAP - 1)});
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {Busy, DotDashOut, NewBitOut, LetterDone, QueueCount}, 7'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int accepted;
        bit got_done;

        pat[0] = 12'b101110000000; pat[1] = 12'b111010101000;
        pat[2] = 12'b111010111010; pat[3] = 12'b111010100000;
        pat[4] = 12'b100000000000; pat[5] = 12'b101011101000;
        pat[6] = 12'b111011101000; pat[7] = 12'b101010100000;
`ifdef MORSE_TRIM_EN
        len_tab[0] = 5; len_tab[1] = 9; len_tab[2] = 11; len_tab[3] = 7;
        len_tab[4] = 1; len_tab[5] = 9; len_tab[6] = 9;  len_tab[7] = 7;
`else
        for (int i = 0; i < 8; i++) len_tab[i] = 12;
`endif

        // Reset held for three edges.
        Reset = 1'b1; Flush = 1'b0; LetterValid = 1'b0; Letter = 3'd0;
        repeat (3) @(negedge ClockIn);
        check("ready_during_reset", LetterReady, 1'b0);
        Reset = 1'b0;
        @(negedge ClockIn);
        check_idle("reset_state");
        check("reset_ready", LetterReady, 1'b1);

        // Single E: one queued letter, LOAD on the following edge.
        LetterValid = 1'b1; Letter = 3'd4;
        @(negedge ClockIn);
        LetterValid = 1'b0;
        check("E queued", {Busy, QueueCount}, {1'b0, 3'd1});
        @(negedge ClockIn);
        expect_letter(4, "E");
        @(negedge ClockIn);
        check_idle("E after");

        // Single C.
        LetterValid = 1'b1; Letter = 3'd2;
        @(negedge ClockIn);
        LetterValid = 1'b0;
        @(negedge ClockIn);
        expect_letter(2, "C");
        @(negedge ClockIn);
        check_idle("C after");

        // A then H on consecutive edges: H's LOAD directly follows A's gap.
        LetterValid = 1'b1; Letter = 3'd0;
        @(negedge ClockIn);
        Letter = 3'd7;
        @(negedge ClockIn);
        LetterValid = 1'b0;
        expect_letter(0, "A");
        @(negedge ClockIn);
        expect_letter(7, "H");
        @(negedge ClockIn);
        check_idle("AH after");

        // Continuous offers from idle: four stored plus one taken by LOAD.
        accepted = 0;
        LetterValid = 1'b1; Letter = 3'd1;
        for (int i = 0; i < 12; i++) begin
            if (QueueCount == 3'd4) check($sformatf("full ready cyc%0d", i), LetterReady, 1'b0);
            if (LetterReady) accepted++;
            @(negedge ClockIn);
        end
        LetterValid = 1'b0;
        check("accepted count", accepted, 5);
        check("queue full", {QueueCount, LetterReady}, {3'd4, 1'b0});
        got_done = 1'b0;
        for (int i = 0; i < 300 && !got_done; i++) begin
            if (LetterDone) got_done = 1'b1;
            else @(negedge ClockIn);
        end
        check("first B done seen", got_done, 1'b1);
        @(negedge ClockIn);
        check("next load", {Busy, DotDashOut, QueueCount, LetterReady}, {1'b1, 1'b0, 3'd4, 1'b0});
        @(negedge ClockIn);
        check("after load", {QueueCount, LetterReady}, {3'd3, 1'b1});
        Flush = 1'b1;
        @(negedge ClockIn);
        Flush = 1'b0;
        check_idle("cont flushed");

        // Queue C, D, E then flush during C's 6th bit.
        LetterValid = 1'b1; Letter = 3'd2;
        @(negedge ClockIn);
        Letter = 3'd3;
        @(negedge ClockIn);
        Letter = 3'd4;
        @(negedge ClockIn);
        LetterValid = 1'b0;
        check("CDE queued", {Busy, QueueCount}, {1'b1, 3'd2});
        repeat (20) @(negedge ClockIn);
        check("C bit5", {Busy, DotDashOut}, {1'b1, pat[2][6]});
        @(negedge ClockIn);
        Flush = 1'b1; LetterValid = 1'b1; Letter = 3'd1;
        #1;
        check("ready during flush", LetterReady, 1'b0);
        @(negedge ClockIn);
        Flush = 1'b0; LetterValid = 1'b0;
        check_idle("flush result");
        for (int i = 0; i < 4; i++) begin
            @(negedge ClockIn);
            check($sformatf("post flush %0d", i), {Busy, QueueCount, LetterDone}, 5'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
